scramble_controller: RTL and testbench
======================================

Name: scramble_controller

Overview:
- Sequences a cube scramble. Samples the free-running random move stream (face/rotation, updated every clock) and rejects illegal codes and repeated faces.
- Issues exactly SCRAMBLE_LEN legal moves to the cube rotation engine over a valid/ready handshake.
- Instantiated at cube top level between the move generator and the rotation engine.

Parameters:
- SCRAMBLE_LEN, 20, number of moves per scramble. Legal range 1..2**CNT_W-1; elaboration error otherwise.
- CNT_W, 5, width of the move counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  begin scramble; sampled only in IDLE
- abort  in  1  cancel scramble; sampled only in FETCH/ISSUE
- gen_face  in  3  random face from move generator (0..5 legal)
- gen_rot  in  2  random rotation from move generator (0=CW, 1=CCW, 2=double)
- mv_valid  out  1  move offered to rotation engine
- mv_ready  in  1  rotation engine accepts move
- mv_face  out  3  offered face
- mv_rot  out  2  offered rotation
- busy  out  1  high from the cycle after start until DONE or abort
- done  out  1  one-cycle pulse after the last move is accepted
- moves_issued  out  CNT_W  handshakes completed in current/last scramble

Behaviour:
- Reset (async, rst=0): state=IDLE; mv_valid=0, mv_face=0, mv_rot=0, busy=0, done=0, moves_issued=0, last_face=FACE_NONE(7).
- All outputs are registered.
- IDLE:
  - start=1 -> FETCH next cycle; busy=1, moves_issued=0, last_face=7.
  - abort is ignored.
- FETCH: evaluate gen_face/gen_rot every cycle.
  - Accept iff gen_face<=5 AND gen_rot<=2 AND gen_face!=last_face.
  - Accept: latch mv_face/mv_rot, set mv_valid=1, go to ISSUE.
  - Reject: stay in FETCH; no output change. No limit on consecutive rejects.
- ISSUE:
  - mv_valid, mv_face and mv_rot hold stable until mv_valid&&mv_ready.
  - Handshake: moves_issued+=1, last_face=mv_face, mv_valid=0 next cycle.
  - Then DONE if the new count==SCRAMBLE_LEN, else FETCH.
- DONE: done=1 for exactly this one cycle; busy=0; go to IDLE. moves_issued holds its final value until the next start.
- Latency and throughput:
  - start in cycle N -> FETCH in N+1 -> earliest mv_valid in N+2.
  - Max throughput is one move per 2 cycles (FETCH+ISSUE).
  - Minimum total is 2*SCRAMBLE_LEN+2 cycles from start to done.
- abort in FETCH or ISSUE:
  - Next cycle: IDLE, mv_valid=0, busy=0, no done pulse.
  - mv_face/mv_rot keep their last values.
  - abort in the same cycle as a handshake: the move counts (moves_issued increments), then IDLE.
- start while not in IDLE is ignored.
- start and abort together in IDLE: start wins.
- Reset asserted mid-scramble: immediate return to reset values; mv_valid drops asynchronously.
- Rotation engine contract: the engine must not see mv_face change while mv_valid=1 and mv_ready=0.

Decomposition:
- cube_pkg (shared):
  - FACE_W=3, ROT_W=2, NUM_FACES=6, FACE_NONE=3'd7.
  - ROT_CW=0, ROT_CCW=1, ROT_DOUBLE=2.
  - Move struct {face, rot}.
  - Controller state enum IDLE/FETCH/ISSUE/DONE.
- No sub-module. The legality check is a few gates inline. The move generator is instantiated beside this block at top level, not inside it.

Test Plan:
- SCRAMBLE_LEN=3, mv_ready=1, gen faces 0,1,2 (rot 0,1,2): start at cycle 0 -> mv_valid at cycles 2,4,6 with (0,0),(1,1),(2,2); done=1 at cycle 7 only; moves_issued=3; busy=0 from cycle 7.
- Repeated face: gen (2,0),(2,1),(2,1),(4,2) -> issued faces 2 then 4; the two face-2 repeats are never offered.
- Illegal codes: gen face 6, face 7 and rot 3 interleaved with legal moves -> none issued; count advances only on legal moves.
- Backpressure: mv_ready=0 for 5 cycles while gen toggles -> mv_valid stays 1 and mv_face/mv_rot stay stable; one handshake on release.
- Abort in ISSUE with mv_ready=0 -> mv_valid=0 and busy=0 next cycle, no done. Abort coincident with a handshake -> moves_issued increments, no done.
- rst=0 mid-ISSUE -> mv_valid, busy and moves_issued all 0 immediately. start pulsed while busy -> count is not cleared.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared cube move types, face/rotation encodings and the move legality helper.
// Pure declarations: no latency, no flow control.
package cube_pkg;

    localparam int FACE_W    = 3;
    localparam int ROT_W     = 2;
    localparam int NUM_FACES = 6;

    localparam logic [FACE_W-1:0] FACE_NONE = 3'd7;

    localparam logic [ROT_W-1:0] ROT_CW     = 2'd0;
    localparam logic [ROT_W-1:0] ROT_CCW    = 2'd1;
    localparam logic [ROT_W-1:0] ROT_DOUBLE = 2'd2;

    typedef struct packed {
        logic [FACE_W-1:0] face;
        logic [ROT_W-1:0]  rot;
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DONE
    } ctrl_state_t;

    // A legal move names a real face and rotation and never turns the same face twice in a row.
    function automatic logic move_legal(input move_t m, input logic [FACE_W-1:0] last_face);
        logic face_ok;
        logic rot_ok;
        face_ok = (m.face < FACE_W'(NUM_FACES)) && (m.face != last_face);
        rot_ok  = (m.rot == ROT_CW) || (m.rot == ROT_CCW) || (m.rot == ROT_DOUBLE);
        return face_ok && rot_ok;
    endfunction

endpackage

// File: rtl/scramble_controller_if.sv
// Move handshake between the scramble controller (master) and the rotation engine (slave).
// Wires only: no latency; the slave throttles through mv_ready.
interface scramble_controller_if;

    logic                       mv_valid;
    logic                       mv_ready;
    logic [cube_pkg::FACE_W-1:0] mv_face;
    logic [cube_pkg::ROT_W-1:0]  mv_rot;

    modport master (
        output mv_valid,
        output mv_face,
        output mv_rot,
        input  mv_ready
    );

    modport slave (
        input  mv_valid,
        input  mv_face,
        input  mv_rot,
        output mv_ready
    );

endinterface

// File: rtl/scramble_controller.sv
// Issues SCRAMBLE_LEN legal moves sampled from the random stream; first move 2 cycles after start.
// Offered move holds stable while mv_ready is low; at most one move per two cycles.
module scramble_controller
    import cube_pkg::*;
#(
    parameter int SCRAMBLE_LEN = 20,
    parameter int CNT_W        = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [FACE_W-1:0]        gen_face,
    input  logic [ROT_W-1:0]         gen_rot,
    scramble_controller_if.master    mv_bus,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         moves_issued
);

    if ((SCRAMBLE_LEN < 1) || (SCRAMBLE_LEN > ((2 ** CNT_W) - 1))) begin : g_bad_len
        $error("scramble_controller: SCRAMBLE_LEN out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(SCRAMBLE_LEN);

    ctrl_state_t        state;
    move_t              mv_q;
    logic               valid_q;
    logic [FACE_W-1:0]  last_face;

    move_t              gen_mv;
    logic [CNT_W-1:0]   cnt_next;
    logic               hs;

    assign gen_mv   = '{face: gen_face, rot: gen_rot};
    assign cnt_next = moves_issued + CNT_W'(1);
    assign hs       = valid_q && mv_bus.mv_ready;

    assign mv_bus.mv_valid = valid_q;
    assign mv_bus.mv_face  = mv_q.face;
    assign mv_bus.mv_rot   = mv_q.rot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            mv_q         <= '0;
            valid_q      <= 1'b0;
            last_face    <= FACE_NONE;
            busy         <= 1'b0;
            done         <= 1'b0;
            moves_issued <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_FETCH;
                        busy         <= 1'b1;
                        moves_issued <= '0;
                        last_face    <= FACE_NONE;
                    end
                end

                ST_FETCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (move_legal(gen_mv, last_face)) begin
                        mv_q    <= gen_mv;
                        valid_q <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // A handshake coinciding with abort still counts the move.
                    if (hs) begin
                        moves_issued <= cnt_next;
                        last_face    <= mv_q.face;
                        valid_q      <= 1'b0;
                        if (abort) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else if (cnt_next == LEN_C) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else if (abort) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scramble_controller.sv
// Randomised and directed bench for scramble_controller with a behavioural model and scoreboard.
module tb_scramble_controller;

    localparam int LEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] gen_face = 3'd0;
    logic [1:0] gen_rot = 2'd0;
    logic       busy;
    logic       done;
    logic [4:0] moves_issued;

    scramble_controller_if bus();

    scramble_controller #(.SCRAMBLE_LEN(LEN), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .gen_face     (gen_face),
        .gen_rot      (gen_rot),
        .mv_bus       (bus),
        .busy         (busy),
        .done         (done),
        .moves_issued (moves_issued)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [4:0] hs_log[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a scramble is "active", and while active it is either looking for
    // a move or offering one; a finished scramble reports done for one cycle.
    bit         m_active = 0;
    bit         m_offer  = 0;
    bit         m_done   = 0;
    int         m_cnt    = 0;
    logic [2:0] m_face   = 3'd0;
    logic [1:0] m_rot    = 2'd0;
    logic [2:0] m_last   = 3'd7;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_offer = 0; m_done = 0; m_cnt = 0;
            m_face = 3'd0; m_rot = 2'd0; m_last = 3'd7;
        end else if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_cnt = 0; m_last = 3'd7;
            end
        end else if (!m_offer) begin
            if (abort) m_active = 0;
            else if (gen_face <= 5 && gen_rot <= 2 && gen_face != m_last) begin
                m_face = gen_face; m_rot = gen_rot; m_offer = 1;
            end
        end else if (bus.mv_ready) begin
            m_cnt++; m_last = m_face; m_offer = 0;
            if (abort) m_active = 0;
            else if (m_cnt == LEN) begin m_active = 0; m_done = 1; end
        end else if (abort) begin
            m_active = 0; m_offer = 0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (rst) begin
            chk("cmp_mv_valid", bus.mv_valid, m_offer);
            chk("cmp_mv_face", bus.mv_face, m_face);
            chk("cmp_mv_rot", bus.mv_rot, m_rot);
            chk("cmp_busy", busy, m_active);
            chk("cmp_done", done, m_done);
            chk("cmp_moves_issued", moves_issued, m_cnt);
            if (bus.mv_valid && bus.mv_ready) begin
                chk("hs_legal", (bus.mv_face <= 5) && (bus.mv_rot <= 2), 1);
                chk("hs_no_repeat", bus.mv_face != m_last, 1);
                hs_log.push_back({bus.mv_face, bus.mv_rot});
            end
        end
    end

    task automatic set_in(input bit s, input bit a, input int gf, input int gr, input bit r);
        start = s;
        abort = a;
        gen_face = 3'(gf);
        gen_rot = 2'(gr);
        bus.mv_ready = r;
    endtask

    task automatic finish_scramble(input string name);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1;
                break;
            end
            set_in(0, 0, $urandom_range(0, 5), $urandom_range(0, 2), 1);
        end
        set_in(0, 0, 0, 0, 1);
        chk(name, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int rf[6] = '{0, 2, 2, 2, 2, 4};
    int rr[6] = '{0, 0, 1, 1, 1, 2};
    int xf[5] = '{0, 6, 7, 1, 3};
    int xr[5] = '{0, 0, 1, 3, 1};

    initial begin
        bus.mv_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mv_valid", bus.mv_valid, 0);
        chk("rst_mv_face", bus.mv_face, 0);
        chk("rst_mv_rot", bus.mv_rot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_moves", moves_issued, 0);
        rst = 1'b1;
        set_in(0, 1, 0, 0, 1);
        repeat (2) @(negedge clk);
        chk("idle_abort_ignored", busy, 0);

        // Basic scramble: faces 0,1,2 with rotations 0,1,2.
        hs_log.delete();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            case (c)
                1: chk("t1_busy_c1", busy, 1);
                2: begin
                    chk("t1_valid_c2", bus.mv_valid, 1);
                    chk("t1_face_c2", bus.mv_face, 0);
                    chk("t1_rot_c2", bus.mv_rot, 0);
                end
                3: chk("t1_valid_c3", bus.mv_valid, 0);
                4: begin
                    chk("t1_valid_c4", bus.mv_valid, 1);
                    chk("t1_face_c4", bus.mv_face, 1);
                    chk("t1_rot_c4", bus.mv_rot, 1);
                end
                6: begin
                    chk("t1_valid_c6", bus.mv_valid, 1);
                    chk("t1_face_c6", bus.mv_face, 2);
                    chk("t1_rot_c6", bus.mv_rot, 2);
                end
                7: begin
                    chk("t1_done_c7", done, 1);
                    chk("t1_busy_c7", busy, 0);
                    chk("t1_moves_c7", moves_issued, 3);
                end
                8: begin
                    chk("t1_done_c8", done, 0);
                    chk("t1_moves_c8", moves_issued, 3);
                end
                default: ;
            endcase
            set_in(c == 0, 0, (c == 0) ? 0 : (c - 1) / 2, (c == 0) ? 0 : (c - 1) / 2, 1);
        end
        chk("t1_hs_count", hs_log.size(), 3);

        // Repeated face is skipped.
        @(negedge clk);
        hs_log.delete();
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) chk("rep_not_offered", bus.mv_valid, 0);
            set_in(c == 0, 0, rf[c], rr[c], 1);
        end
        finish_scramble("rep_finish");
        chk("rep_hs_count", hs_log.size(), 3);
        if (hs_log.size() >= 2) begin
            chk("rep_first", hs_log[0], {3'd2, 2'd0});
            chk("rep_second", hs_log[1], {3'd4, 2'd2});
        end

        // Illegal codes never issue.
        hs_log.delete();
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) begin
                chk("ill_no_valid", bus.mv_valid, 0);
                chk("ill_no_count", moves_issued, 0);
            end
            set_in(c == 0, 0, xf[c], xr[c], 1);
        end
        finish_scramble("ill_finish");
        if (hs_log.size() >= 1) chk("ill_first", hs_log[0], {3'd3, 2'd1});
        else chk("ill_hs_count", hs_log.size(), 3);

        // Backpressure: five stalled cycles, then one handshake.
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c >= 2 && c <= 7) begin
                chk("bp_valid", bus.mv_valid, 1);
                chk("bp_face", bus.mv_face, 5);
                chk("bp_rot", bus.mv_rot, 2);
            end
            if (c == 8) begin
                chk("bp_released", bus.mv_valid, 0);
                chk("bp_moves", moves_issued, 1);
            end
            if (c <= 1) set_in(c == 0, 0, 5, 2, 0);
            else set_in(0, 0, $urandom_range(0, 7), $urandom_range(0, 3), c >= 7);
        end
        finish_scramble("bp_finish");

        // Abort while stalled in ISSUE.
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3) begin
                chk("ab_valid", bus.mv_valid, 0);
                chk("ab_busy", busy, 0);
                chk("ab_done", done, 0);
                chk("ab_face_kept", bus.mv_face, 0);
                chk("ab_rot_kept", bus.mv_rot, 1);
            end
            if (c == 4) chk("ab_done_c4", done, 0);
            set_in(c == 0, c == 2, 0, 1, 0);
        end

        // Abort coincident with a handshake.
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 5) begin
                chk("abhs_moves", moves_issued, 2);
                chk("abhs_valid", bus.mv_valid, 0);
                chk("abhs_busy", busy, 0);
                chk("abhs_done", done, 0);
            end
            if (c == 6) chk("abhs_done_c6", done, 0);
            set_in(c == 0, c == 4, (c >= 3) ? 2 : 1, 0, 1);
        end

        // Start while busy is ignored, then reset mid-ISSUE.
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) begin
                chk("sb_moves_kept", moves_issued, 1);
                chk("sb_busy", busy, 1);
            end
            if (c == 5) chk("sb_valid", bus.mv_valid, 1);
            if (c <= 3) set_in(c == 0 || c == 3, 0, 3, 0, 1);
            else set_in(0, 0, 4, 0, 0);
        end
        #3;
        rst = 1'b0;
        #1;
        chk("mrst_valid", bus.mv_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_moves", moves_issued, 0);
        @(negedge clk);
        rst = 1'b1;
        set_in(0, 0, 0, 0, 1);

        // Random scrambles with stalls, stray starts and aborts.
        for (int s = 0; s < 40; s++) begin
            bit ok;
            ok = 0;
            @(negedge clk);
            set_in(1, 0, $urandom_range(0, 7), $urandom_range(0, 3), 1);
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (!busy && !done) begin
                    ok = 1;
                    break;
                end
                set_in($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                       $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3) != 0);
            end
            set_in(0, 0, 0, 0, 1);
            chk("rand_finish", ok, 1);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
